// File: rtl/fish_school.sv
// fish_school: per-frame motion controller for the aquarium fish sprites.
// Holds position and speed for NUM_FISH fish. Each accepted frame tick starts
// one sweep that updates one fish per cycle, in index order. A fish that would
// step past the left edge respawns at the right edge, with its height and
// speed drawn from a 16-bit LFSR.
module fish_school #(
    parameter int unsigned NUM_FISH  = 4,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned FISH_H    = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_tick,
    input  logic                     freeze,
    output logic [NUM_FISH*10-1:0]   fish_x,
    output logic [NUM_FISH*10-1:0]   fish_y,
    output logic                     busy,
    output logic                     overrun,
    output logic [7:0]               frame_count
);

    localparam int unsigned IDXW = (NUM_FISH > 1) ? $clog2(NUM_FISH) : 1;
    localparam logic [8:0]  SPAN = 9'(SCREEN_H - FISH_H);

    typedef enum logic {
        IDLE,
        UPDATE
    } state_t;

    state_t          state, state_next;
    logic [IDXW-1:0] idx;
    logic [9:0]      x   [NUM_FISH];
    logic [9:0]      y   [NUM_FISH];
    logic [2:0]      spd [NUM_FISH];
    logic [15:0]     lfsr;

    logic            start;
    logic            move;
    logic [9:0]      cur_x;
    logic [2:0]      cur_spd;
    logic [8:0]      spawn_y;
    logic [9:0]      new_x;
    logic [9:0]      new_y;
    logic [2:0]      new_spd;
    logic [15:0]     lfsr_next;

    // Next-state logic: accept a tick in IDLE unless frozen; leave UPDATE after the last fish
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick && !freeze) begin
                    state_next = UPDATE;
                    start      = 1'b1;
                end
            end
            UPDATE: begin
                if (idx == IDXW'(NUM_FISH - 1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Update of the fish selected by idx: step left, or respawn from the LFSR
    always_comb begin
        cur_x     = x[idx];
        cur_spd   = spd[idx];
        move      = cur_x > {7'd0, cur_spd};
        spawn_y   = (lfsr[8:0] >= SPAN) ? (lfsr[8:0] - SPAN) : lfsr[8:0];
        new_x     = move ? (cur_x - {7'd0, cur_spd}) : 10'(SCREEN_W);
        new_y     = move ? y[idx] : {1'b0, spawn_y};
        new_spd   = move ? cur_spd : (3'd1 + {1'b0, lfsr[11:10]});
        lfsr_next = move ? lfsr
                         : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // State register, fish table, LFSR and status counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            lfsr        <= LFSR_SEED;
            overrun     <= 1'b0;
            frame_count <= '0;
            for (int unsigned i = 0; i < NUM_FISH; i++) begin
                x[i]   <= 10'(SCREEN_W - 160 * i);
                y[i]   <= 10'(60 + 100 * i);
                spd[i] <= 3'((i % 4) + 1);
            end
        end else begin
            state <= state_next;
            if (start) begin
                idx         <= '0;
                frame_count <= frame_count + 8'd1;
            end
            if (state == UPDATE) begin
                x[idx]   <= new_x;
                y[idx]   <= new_y;
                spd[idx] <= new_spd;
                lfsr     <= lfsr_next;
                idx      <= idx + 1'b1;
                if (frame_tick)
                    overrun <= 1'b1;
            end
        end
    end

    // Pack the fish table onto the renderer buses
    always_comb begin
        fish_x = '0;
        fish_y = '0;
        for (int unsigned i = 0; i < NUM_FISH; i++) begin
            fish_x[10*i +: 10] = x[i];
            fish_y[10*i +: 10] = y[i];
        end
    end

    assign busy = (state == UPDATE);

endmodule

// File: tb/tb_fish_school.sv
// tb_fish_school: scoreboard bench for fish_school with default parameters.
// A behavioural model predicts the bus contents after every cycle of a sweep;
// the predictions are queued when a tick is driven and popped cycle by cycle.
module tb_fish_school;

    localparam int NF = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_tick = 1'b0;
    logic             freeze = 1'b0;
    logic [NF*10-1:0] fish_x;
    logic [NF*10-1:0] fish_y;
    logic             busy;
    logic             overrun;
    logic [7:0]       frame_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NF*10-1:0] x;
        logic [NF*10-1:0] y;
        logic             busy;
    } snap_t;

    snap_t sbq[$];

    int unsigned mx [NF];
    int unsigned my [NF];
    int unsigned ms [NF];
    logic [15:0] ml;
    logic [7:0]  mcount;
    logic        mover;

    fish_school #(
        .NUM_FISH  (NF),
        .SCREEN_W  (640),
        .SCREEN_H  (480),
        .FISH_H    (5),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .freeze      (freeze),
        .fish_x      (fish_x),
        .fish_y      (fish_y),
        .busy        (busy),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            mx[i] = 640 - 160 * i;
            my[i] = 60 + 100 * i;
            ms[i] = (i % 4) + 1;
        end
        ml     = 16'hACE1;
        mcount = 8'd0;
        mover  = 1'b0;
    endtask

    function automatic logic [NF*10-1:0] pack_x();
        logic [NF*10-1:0] v;
        for (int i = 0; i < NF; i++) v[10*i +: 10] = mx[i][9:0];
        return v;
    endfunction

    function automatic logic [NF*10-1:0] pack_y();
        logic [NF*10-1:0] v;
        for (int i = 0; i < NF; i++) v[10*i +: 10] = my[i][9:0];
        return v;
    endfunction

    task automatic model_step(input int i);
        int unsigned yy;
        if (mx[i] > ms[i]) begin
            mx[i] = mx[i] - ms[i];
        end else begin
            mx[i] = 640;
            yy = ml[8:0];
            if (yy >= 475) yy = yy - 475;
            my[i] = yy;
            ms[i] = 1 + ml[11:10];
            ml = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // retick: 0 for none, else a second tick sampled at edge T+retick (1..NF)
    task automatic do_tick(input int retick);
        snap_t s;
        @(negedge clk);
        frame_tick = 1'b1;
        mcount = mcount + 8'd1;
        s.x = pack_x(); s.y = pack_y(); s.busy = 1'b1;
        sbq.push_back(s);
        for (int k = 0; k < NF; k++) begin
            model_step(k);
            s.x = pack_x(); s.y = pack_y(); s.busy = (k != NF - 1);
            sbq.push_back(s);
        end
        if (retick >= 1 && retick <= NF) mover = 1'b1;
        for (int j = 0; j <= NF; j++) begin
            @(negedge clk);
            frame_tick = (j + 1 == retick);
            s = sbq.pop_front();
            check("sweep_x", fish_x, s.x);
            check("sweep_y", fish_y, s.y);
            check("sweep_busy", busy, s.busy);
        end
        frame_tick = 1'b0;
        check("frame_count", frame_count, mcount);
        check("overrun", overrun, mover);
    endtask

    initial begin
        logic seen_busy;
        model_reset();

        // Reset held for two edges
        rst_n = 1'b0;
        idle(2);
        check("rst_x", fish_x, {10'd160, 10'd320, 10'd480, 10'd640});
        check("rst_y", fish_y, {10'd360, 10'd260, 10'd160, 10'd60});
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_count", frame_count, 8'd0);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_x", fish_x, pack_x());

        // Single tick
        do_tick(0);
        check("tick1_x", fish_x, {10'd156, 10'd317, 10'd478, 10'd639});
        check("tick1_y", fish_y, {10'd360, 10'd260, 10'd160, 10'd60});
        check("tick1_count", frame_count, 8'd1);

        // Ticks 2..40 at frame spacing; tick 40 respawns fish3 only
        for (int t = 2; t <= 40; t++) begin
            idle(795);
            do_tick(0);
        end
        check("resp_x", fish_x, {10'd640, 10'd200, 10'd400, 10'd600});
        check("resp_y3", fish_y[39:30], 10'd225);
        idle(20);
        do_tick(0);
        check("resp_spd4", fish_x[39:30], 10'd636);

        // Freeze across three ticks
        freeze = 1'b1;
        seen_busy = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk); frame_tick = 1'b1;
            @(negedge clk); frame_tick = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (busy !== 1'b0) seen_busy = 1'b1;
            end
        end
        check("frz_busy", seen_busy, 1'b0);
        check("frz_x", fish_x, pack_x());
        check("frz_y", fish_y, pack_y());
        check("frz_count", frame_count, mcount);
        freeze = 1'b0;
        idle(3);
        do_tick(0);

        // Overrun: second tick two cycles after the first, then sticky
        idle(5);
        do_tick(2);
        idle(5);
        do_tick(0);
        check("ovr_sticky", overrun, 1'b1);

        // Dense ticks to exercise further respawns and the LFSR sequence
        for (int t = 0; t < 300; t++) begin
            idle(2);
            do_tick(0);
        end

        // Reset mid-sweep: rst_n low sampled at edge T+2
        idle(5);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        check("mid_rst_x", fish_x, {10'd160, 10'd320, 10'd480, 10'd640});
        check("mid_rst_y", fish_y, {10'd360, 10'd260, 10'd160, 10'd60});
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_overrun", overrun, 1'b0);
        check("mid_rst_count", frame_count, 8'd0);
        idle(3);
        do_tick(0);
        check("again_x", fish_x, {10'd156, 10'd317, 10'd478, 10'd639});
        check("again_count", frame_count, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
